// File: rtl/dct_block_sequencer.sv
// Streams 8x8 pixel blocks MEM_IN -> 2D-DCT -> MEM_OUT, one row per cycle, with a cap on in-flight blocks.
// Optional watchdog (timeout_err port) is built only when DCT_SEQ_TIMEOUT_EN is defined.
module dct_block_sequencer #(
    parameter int ADDR_W          = 15,
    parameter int IN_W            = 64,
    parameter int OUT_W           = 80,
    parameter int NUM_BLOCKS      = 4096,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYC     = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_in_rd_en,
    output logic [ADDR_W-1:0] mem_in_addr,
    input  logic [IN_W-1:0]   mem_in_rdata,
    input  logic              dct_in_ready,
    output logic              dct_in_valid,
    output logic [IN_W-1:0]   dct_in_data,
    output logic              dct_in_sob,
    output logic              dct_in_eob,
    input  logic              dct_out_valid,
    input  logic [OUT_W-1:0]  dct_out_data,
    output logic              mem_out_wr_en,
    output logic [ADDR_W-1:0] mem_out_addr,
    output logic [OUT_W-1:0]  mem_out_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow_err
`ifdef DCT_SEQ_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int BLK_W  = ADDR_W - 2;
    localparam int STAGES = 1;

    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(NUM_BLOCKS * 8);
    localparam logic [BLK_W-1:0] MAX_C   = BLK_W'(MAX_OUTSTANDING);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    if (MAX_OUTSTANDING < 1) begin : g_bad_outstanding
        $error("MAX_OUTSTANDING must be at least 1");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    logic [1:0]        state;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [BLK_W-1:0]  rd_blk;
    logic [BLK_W-1:0]  wr_blk;
    logic [BLK_W-1:0]  blk_diff;
    logic [STAGES-1:0] vld_pipe;
    logic              issue;
    logic              accept;
    logic              restart;
    logic              active;

    assign active   = (state == S_RUN) || (state == S_DRAIN);
    assign blk_diff = rd_blk - wr_blk;
    assign restart  = start && ((state == S_IDLE) || (state == S_DONE));

    // rd_blk only counts fully issued blocks, so a partially read block never blocks itself.
    assign issue  = (state == S_RUN) && (rd_cnt < TOTAL_C) && dct_in_ready && (blk_diff < MAX_C);
    assign accept = dct_out_valid && active && (wr_cnt < TOTAL_C);

    assign mem_in_rd_en = issue;
    assign mem_in_addr  = rd_cnt[ADDR_W-1:0];

    // SRAM data lands one cycle after the strobe, aligned with the registered valid.
    assign dct_in_valid = vld_pipe[STAGES-1];
    assign dct_in_data  = dct_in_valid ? mem_in_rdata : '0;

    assign busy = active;
    assign done = (state == S_DONE);

`ifdef DCT_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_hit;
    logic            expecting;

    assign expecting = active && (wr_blk < rd_blk);
    assign wd_hit    = (wd_cnt == WD_W'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (restart || dct_out_valid || wd_hit) begin
                wd_cnt <= '0;
            end else if (expecting) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            rd_cnt        <= '0;
            wr_cnt        <= '0;
            rd_blk        <= '0;
            wr_blk        <= '0;
            vld_pipe      <= '0;
            dct_in_sob    <= 1'b0;
            dct_in_eob    <= 1'b0;
            mem_out_wr_en <= 1'b0;
            mem_out_addr  <= '0;
            mem_out_wdata <= '0;
            overflow_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_RUN;
                S_RUN:   if (rd_cnt == TOTAL_C) state <= S_DRAIN;
                S_DRAIN: if ((wr_cnt == TOTAL_C) && !mem_out_wr_en) state <= S_DONE;
                S_DONE:  if (start) state <= S_RUN;
                default: state <= S_IDLE;
            endcase
`ifdef DCT_SEQ_TIMEOUT_EN
            if (wd_hit) begin
                state <= S_DONE;
            end
`endif

            if (restart) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
                rd_blk <= '0;
                wr_blk <= '0;
            end else begin
                if (issue) begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_cnt[2:0] == 3'd7) rd_blk <= rd_blk + 1'b1;
                end
                if (accept) begin
                    wr_cnt <= wr_cnt + 1'b1;
                    if (wr_cnt[2:0] == 3'd7) wr_blk <= wr_blk + 1'b1;
                end
            end

            vld_pipe[0] <= issue;
            dct_in_sob  <= issue && (rd_cnt[2:0] == 3'd0);
            dct_in_eob  <= issue && (rd_cnt[2:0] == 3'd7);

            mem_out_wr_en <= accept;
            if (accept) begin
                mem_out_addr  <= wr_cnt[ADDR_W-1:0];
                mem_out_wdata <= dct_out_data;
            end

            // A result row nobody asked for is dropped and remembered until reset.
            if (dct_out_valid && !accept) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/dct_block_sequencer.md
Name: dct_block_sequencer

Overview:
- Streams the 8x8 image blocks from the input SRAM (32768x64, 8 pixels per word) through the pipelined 2D-DCT into the output SRAM (32768x80, 8 coefficients x 10 bits per word).
- Generates the read and write addresses, tags block boundaries for the DCT, and bounds how many blocks the DCT may hold at once.
- Sits in top_memory_test between MEM_IN, the DCT core and MEM_OUT.
- Sustains one row per cycle, so a full image completes in about 32.8k cycles.

Parameters:
- ADDR_W, 15, SRAM address width.
- IN_W, 64, input row width.
- OUT_W, 80, output row width.
- NUM_BLOCKS, 4096, 8x8 blocks per image. Total rows TOTAL = NUM_BLOCKS*8.
- MAX_OUTSTANDING, 4, maximum blocks read but not fully written.
- TIMEOUT_CYC, 256, watchdog limit; used only with the optional feature.

Ports:
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-low reset.
- start, in, 1, one-cycle pulse that begins an image; honoured in IDLE and DONE only.
- mem_in_rd_en, out, 1, read strobe to MEM_IN.
- mem_in_addr, out, ADDR_W, MEM_IN read address.
- mem_in_rdata, in, IN_W, MEM_IN data, valid 1 cycle after rd_en.
- dct_in_ready, in, 1, DCT can accept rows.
- dct_in_valid, out, 1, row valid to the DCT.
- dct_in_data, out, IN_W, row to the DCT.
- dct_in_sob, out, 1, first row of a block.
- dct_in_eob, out, 1, last row of a block.
- dct_out_valid, in, 1, DCT result row valid.
- dct_out_data, in, OUT_W, DCT result row.
- mem_out_wr_en, out, 1, write strobe to MEM_OUT.
- mem_out_addr, out, ADDR_W, MEM_OUT write address.
- mem_out_wdata, out, OUT_W, MEM_OUT write data.
- busy, out, 1, high in RUN and DRAIN.
- done, out, 1, high in DONE.
- overflow_err, out, 1, sticky flag for a result row arriving when not expected.

Behaviour:
- States and transitions:
  - IDLE → RUN on start.
  - RUN → DRAIN when rd_cnt == TOTAL.
  - DRAIN → DONE when wr_cnt == TOTAL and no write is pending.
  - DONE → RUN on start, which also clears the counters.
- Reset (reset==0 at a clock edge), whether idle or mid-image:
  - State goes to IDLE.
  - rd_cnt, wr_cnt, rd_blk and wr_blk clear to 0.
  - All outputs go to 0, including overflow_err and the pipeline valids.
  - Any read or write in flight is dropped; MEM_OUT contents are left untouched.
- Counters: rd_cnt and wr_cnt are ADDR_W+1 bits wide. Addresses are the low ADDR_W bits.
- Read issue, in RUN, in a cycle where all three hold:
  - rd_cnt < TOTAL,
  - dct_in_ready == 1,
  - (rd_blk - wr_blk) < MAX_OUTSTANDING.
  - On issue: mem_in_rd_en=1 and mem_in_addr=rd_cnt (combinational from registered state); rd_cnt increments; rd_blk increments when rd_cnt[2:0]==7.
- DCT input path:
  - A registered valid/sob/eob pipe, 1 stage deep, follows each issue.
  - The next cycle: dct_in_valid=1, dct_in_data=mem_in_rdata, dct_in_sob=(row==0), dct_in_eob=(row==7).
  - The DCT must accept every row presented; dct_in_ready gates issue only, so the DCT must tolerate one row after it deasserts ready.
- Write path:
  - Each cycle dct_out_valid==1 and wr_cnt < TOTAL, register mem_out_wr_en=1, mem_out_addr=wr_cnt and mem_out_wdata=dct_out_data.
  - The write appears exactly 1 cycle after dct_out_valid.
  - wr_cnt increments; wr_blk increments when wr_cnt[2:0]==7.
- dct_out_valid in IDLE or DONE, or with wr_cnt == TOTAL: no write, overflow_err set.
- Reads and writes are independent, so the same cycle may carry both a read and a write.
- When the outstanding limit is reached, issue stalls until the final row of the oldest block is written; the first issue can then occur in the same cycle wr_blk updates.
- start in RUN or DRAIN: ignored.
- Wrap-around: with NUM_BLOCKS=4096, the last address is 32767. Counter overflow cannot occur because issue stops at TOTAL.

Optional Feature:
- Macro: DCT_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter counts cycles in RUN or DRAIN with no dct_out_valid while wr_blk < rd_blk (result rows are expected).
  - Reaching TIMEOUT_CYC sets a sticky output timeout_err and forces DONE.
  - The counter clears on any dct_out_valid and on reset.
- Undefined: no port timeout_err, no counter, and the FSM waits indefinitely.

Test Plan:
- Reset, then start with an ideal DCT (ready=1, 20-cycle latency) and NUM_BLOCKS=4096:
  - mem_in_addr steps 0..32767 with one read per cycle and no gap after block 3.
  - MEM_OUT[i] equals the model result; done is asserted by cycle ~32800.
- NUM_BLOCKS=2, DCT latency 100: reads stop at address 15 until writes occur; sob on rows 0 and 8, eob on rows 7 and 15; done after the 16th write.
- MAX_OUTSTANDING=1, DCT latency 30:
  - Block 1 read starts the cycle after block 0 row 7 is written.
  - rd_blk - wr_blk never exceeds 1.
- Toggle dct_in_ready 1/0 every 3 cycles: exactly one row is delivered after each deassert, and no row is lost or duplicated (checksum of 32768 rows matches).
- Assert reset mid-image at row 5000, then start again: counters restart at 0 and the full image output matches; pulse dct_out_valid in IDLE → overflow_err=1.
- With DCT_SEQ_TIMEOUT_EN and TIMEOUT_CYC=256, the DCT never returns rows: timeout_err=1 and done=1 at 256 cycles after the last expected activity.
